// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings,
// controller states and the single-cycle / iterative classification.
package seq_alu_pkg;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_NOT = 3'b101;
    localparam logic [2:0] MODE_MUL = 3'b110;
    localparam logic [2:0] MODE_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // MUL always iterates; DIV iterates only when the divisor is non-zero,
    // because divide-by-zero is answered immediately with fixed values.
    function automatic logic is_iterative(input logic [2:0] mode, input logic b_nonzero);
        return (mode == MODE_MUL) || ((mode == MODE_DIV) && b_nonzero);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider.
// One bit per cycle for WIDTH cycles. lo/hi present the value produced by
// the current iteration, so on the cycle done is high they carry the final
// product {hi,lo} or quotient (lo) / remainder (hi) and can be registered
// by the parent on that same edge.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_bit;

    // One iteration step. MUL: lo holds the remaining multiplier bits, hi the
    // partial product; add b when the current multiplier bit is set and shift
    // the (WIDTH+1)-bit sum right into {hi,lo}. DIV: lo holds the dividend
    // bits still to bring down (and collects quotient bits), hi the partial
    // remainder; a trial subtract decides whether to keep the difference.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        trial   = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, b_q};
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (div_q) begin
            if (!trial[WIDTH+1]) begin
                hi_d = trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = add_sum[WIDTH:1];
            lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // A kept difference is always below b, so the bit above the remainder
    // width is zero whenever it would be used.
    assign unused_trial_bit = trial[WIDTH];

    assign lo   = lo_d;
    assign hi   = hi_d;
    assign done = busy_q && (cnt_q == '0);

    // Operand capture on start, then WIDTH iterations counting WIDTH-1 down to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            b_q    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= CNT_W'(WIDTH - 1);
            lo_q   <= a;
            hi_q   <= '0;
            b_q    <= b;
        end else if (busy_q) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake. Single-cycle ops (and divide by
// zero) are computed combinationally and registered on the accept edge;
// MUL and DIV are handed to the iterative unit and the controller stalls
// the handshake until it finishes. Outputs hold until the next out_valid.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_dz
);

    state_t state_q, state_d;

    logic             accept;
    logic             iterative;
    logic             md_start;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_done;
    logic             op_div_q;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   addsub;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_c;
    logic             alu_v;
    logic             alu_dz;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             flag_c_q;
    logic             flag_v_q;
    logic             flag_z_q;
    logic             flag_n_q;
    logic             flag_dz_q;

    // Ready whenever no iteration is running; the DONE cycle accepts again.
    // Held low while rst is asserted so nothing is accepted during reset.
    assign in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE));
    assign accept    = in_valid && in_ready;
    assign iterative = is_iterative(mode, |b);
    assign md_start  = accept && iterative;

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (mode == MODE_DIV),
        .a      (a),
        .b      (b),
        .lo     (md_lo),
        .hi     (md_hi),
        .done   (md_done)
    );

    // Single-cycle datapath. SUB reuses the adder with b inverted, so cin=1
    // means "no borrow in" and carry-out=1 means "no borrow out".
    always_comb begin
        op_b    = (mode == MODE_SUB) ? ~b : b;
        addsub  = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_hi  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        case (mode)
            MODE_ADD, MODE_SUB: begin
                alu_res = addsub[WIDTH-1:0];
                alu_c   = addsub[WIDTH];
                alu_v   = (a[WIDTH-1] == op_b[WIDTH-1]) && (addsub[WIDTH-1] != a[WIDTH-1]);
            end
            MODE_AND: alu_res = a & b;
            MODE_OR:  alu_res = a | b;
            MODE_XOR: alu_res = a ^ b;
            MODE_NOT: alu_res = ~a;
            MODE_DIV: begin
                // Only reaches the output registers when b==0.
                alu_res = '1;
                alu_hi  = a;
                alu_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // Controller next state: start iterating on an accepted MUL/DIV, leave
    // BUSY when the iterative unit signals its final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = md_start ? BUSY : IDLE;
            BUSY:       state_d = md_done ? DONE : BUSY;
            default:    state_d = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember whether the running iteration is a divide (for the V flag).
    always_ff @(posedge clk) begin
        if (rst) begin
            op_div_q <= 1'b0;
        end else if (md_start) begin
            op_div_q <= (mode == MODE_DIV);
        end
    end

    // Result and flag registers: load on a single-cycle accept or on the
    // final iteration; otherwise hold. out_valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_dz_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && !iterative) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                result_hi_q <= alu_hi;
                flag_c_q    <= alu_c;
                flag_v_q    <= alu_v;
                flag_z_q    <= (alu_res == '0);
                flag_n_q    <= alu_res[WIDTH-1];
                flag_dz_q   <= alu_dz;
            end else if ((state_q == BUSY) && md_done) begin
                out_valid_q <= 1'b1;
                result_q    <= md_lo;
                result_hi_q <= md_hi;
                flag_c_q    <= 1'b0;
                flag_v_q    <= !op_div_q && (md_hi != '0);
                flag_z_q    <= (md_lo == '0);
                flag_n_q    <= md_lo[WIDTH-1];
                flag_dz_q   <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_dz   = flag_dz_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the 3-bit mode encoding and the carry-in/overflow semantics.
- Adds a valid/ready handshake, registered results and flags, and multi-cycle unsigned multiply and divide.
- Sits between the datapath register file and writeback; one operation is in flight at a time.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operation request.
in_ready  out  1  block can accept a request this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in, used by ADD/SUB only.
mode  in  3  operation select.
out_valid  out  1  one-cycle pulse; result and flags are valid.
result  out  WIDTH  low result / quotient.
result_hi  out  WIDTH  MUL high half / DIV remainder; 0 for the other modes.
flag_c  out  1  carry-out.
flag_v  out  1  overflow.
flag_z  out  1  result==0.
flag_n  out  1  result[WIDTH-1].
flag_dz  out  1  divide by zero.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0, except in_ready=1 in the first cycle after rst deasserts.
  - State returns to IDLE. Any in-flight MUL/DIV is aborted with no out_valid.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. a, b, cin and mode are latched at that edge; later changes to the inputs have no effect.
- Modes:
  - 000 ADD: {c,r} = a+b+cin; V = signed overflow.
  - 001 SUB: {c,r} = a+~b+cin (cin=1 means no borrow-in); C = carry-out (1 = no borrow); V = signed overflow.
  - 010 AND, 011 OR, 100 XOR, 101 NOT a: C=0, V=0.
  - 110 MUL: unsigned, 2*WIDTH-bit product; result=low half, result_hi=high half; V = (result_hi != 0); C=0.
  - 111 DIV: unsigned restoring division; result=quotient, result_hi=remainder; C=0, V=0.
- Z and N are always computed on result only.
- Latency, measured from the acceptance edge to the cycle out_valid is high:
  - Modes 000–101: 1 cycle. in_ready stays 1, so back-to-back requests are accepted every cycle and each produces its own out_valid pulse.
  - MUL, and DIV with b != 0: WIDTH+1 cycles.
    - FSM is IDLE -> BUSY (WIDTH iteration cycles, counter WIDTH-1 down to 0) -> DONE.
    - in_ready=0 for the WIDTH BUSY cycles and returns to 1 in the DONE cycle. out_valid is asserted in the DONE cycle.
    - A request presented in the DONE cycle is accepted.
  - DIV with b==0: no iteration, latency 1. result = all ones, result_hi = a, flag_dz=1.
- flag_dz is 0 for every other operation.
- result, result_hi and all flags hold their values until the next out_valid. out_valid is never high for more than one consecutive cycle per operation.
- in_valid while in_ready=0 is ignored; it is not queued.
- Reserved or unknown states return to IDLE.

Decomposition:
- Package seq_alu_pkg:
  - mode localparams MODE_ADD..MODE_DIV (3'b000..3'b111);
  - FSM state typedef {IDLE, BUSY, DONE}.
- One sub-module: seq_alu_muldiv, the iterative shift-add multiplier / restoring divider.
  - Inputs: start, is_div, a, b.
  - Outputs: lo, hi, done.
- The top level holds the combinational single-cycle ops, the flag logic, the handshake and the output registers.

Test Plan:
- WIDTH=8: ADD a=8'h7F b=8'h01 cin=0 -> one cycle later out_valid=1, result=8'h80, V=1, C=0, N=1, Z=0.
- SUB a=8'h05 b=8'h05 cin=1 -> result=8'h00, Z=1, C=1, V=0. Then back-to-back AND 8'hF0&8'h3C and XOR on the following cycles -> 8'h30 and the XOR value on consecutive out_valid pulses.
- MUL a=8'hFF b=8'hFF -> in_ready low for exactly 8 cycles; out_valid 9 cycles after acceptance; result=8'h01, result_hi=8'hFE, V=1. Changing a/b during BUSY does not affect the result; in_valid during BUSY is not accepted.
- DIV a=8'd200 b=8'd7 -> result=8'd28, result_hi=8'd4, dz=0, latency 9. DIV a=8'h2A b=0 -> latency 1, result=8'hFF, result_hi=8'h2A, flag_dz=1.
- rst asserted on the 4th BUSY cycle of a MUL -> no out_valid; all outputs 0; in_ready=1 after release. A following ADD 3+4 yields 7.
- WIDTH=4 regression: replay the legacy 4-bit vectors for modes 000–101 (e.g. ADD 4'b0101+4'b1010 cin=1 -> 4'b0000, C=1, Z=1) -> flag and result values bit-identical to the previous ALU.
